// File: rtl/conv_quant_pack_pkg.sv
// Shared definitions for the conv post-processing stage: mode encodings,
// FSM states and the packing geometry.
package conv_quant_pack_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'd0,
      MODE_CONV1 = 2'd1,
      MODE_CONV2 = 2'd2,
      MODE_DONE  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int DATA_W = 32;
   localparam int ACT_W  = 8;
   localparam int PACK   = 4;
   localparam int LANE_W = $clog2(PACK);
   localparam int CNT_W  = 12;

endpackage

// File: rtl/conv_quant_pack_qrs.sv
// quant_relu_sat: two-stage bias add / ReLU / round / shift / saturate datapath
// with a valid bit travelling alongside the data.
module quant_relu_sat
   import conv_quant_pack_pkg::*;
#(
   parameter int BIAS_SHIFT = 4
) (
   input  logic                     clk,
   input  logic                     srstn,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] data_in,
   input  logic signed [7:0]        bias,
   input  logic [4:0]               out_shift,
   output logic                     out_valid,
   output logic [ACT_W-1:0]         act
);

   localparam int SUM_W = DATA_W + 1;
   localparam logic [SUM_W:0] ACT_MAX = (SUM_W+1)'(2**(ACT_W-1) - 1);

   function automatic logic signed [SUM_W-1:0] bias_add(
      input logic signed [DATA_W-1:0] d,
      input logic signed [7:0]        b
   );
      logic signed [SUM_W-1:0] bs;
      logic signed [SUM_W-1:0] ds;
      bs = {{(SUM_W-8){b[7]}}, b};
      ds = {d[DATA_W-1], d};
      return ds + (bs <<< BIAS_SHIFT);
   endfunction

   // Extra headroom bit keeps the rounding increment from wrapping.
   function automatic logic [ACT_W-1:0] round_sat(
      input logic signed [SUM_W-1:0] s,
      input logic [4:0]              sh
   );
      logic [SUM_W:0] r;
      if (s < 0) r = '0;
      else       r = {1'b0, s};
      if (sh != 5'd0)
         r = (r + ((SUM_W+1)'(1) << (sh - 5'd1))) >> sh;
      if (r > ACT_MAX) return ACT_MAX[ACT_W-1:0];
      return r[ACT_W-1:0];
   endfunction

   logic signed [SUM_W-1:0] sum_p1;
   logic                    vld_p1;

   // S1: sign-extended bias add
   always_ff @(posedge clk) begin
      if (!srstn) begin
         vld_p1 <= 1'b0;
         sum_p1 <= '0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) sum_p1 <= bias_add(data_in, bias);
      end
   end

   // S2: ReLU, round, shift, saturate
   always_ff @(posedge clk) begin
      if (!srstn) begin
         out_valid <= 1'b0;
         act       <= '0;
      end else begin
         out_valid <= vld_p1 & ~flush;
         if (vld_p1) act <= round_sat(sum_p1, out_shift);
      end
   end

endmodule

// File: rtl/conv_quant_pack.sv
// Quantises pooled sums to 8-bit activations, packs four per 32-bit word and
// streams the words into the feature-map SRAM, flushing a partial last word.
module conv_quant_pack
   import conv_quant_pack_pkg::*;
#(
   parameter int BIAS_SHIFT = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int CONV1_BASE = 0,
   parameter int CONV2_BASE = 256
) (
   input  logic                  clk,
   input  logic                  srstn,
   input  logic [1:0]            mode,
   input  logic                  frame_start,
   input  logic [CNT_W-1:0]      pixel_total,
   input  logic [4:0]            out_shift,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     data_in,
   input  logic [7:0]            bias,
   output logic                  sram_wen,
   output logic [ADDR_WIDTH-1:0] sram_waddr,
   output logic [DATA_W-1:0]     sram_wdata,
   output logic                  busy,
   output logic                  done
);

   state_e                  state;
   logic [CNT_W-1:0]        total_q;
   logic [CNT_W-1:0]        in_cnt;
   logic [CNT_W-1:0]        out_cnt;
   logic [4:0]              shift_q;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [LANE_W-1:0]       lane;
   logic [DATA_W-1:0]       pack_word;
   logic                    last_wr;

   logic                    accept;
   logic                    q_valid;
   logic [ACT_W-1:0]        q_act;
   logic [ADDR_WIDTH-1:0]   base;
   logic [4:0]              lane_sh;
   logic [DATA_W-1:0]       lane_word;
   logic                    pix_last;

   // A pixel arriving with frame_start belongs to the new frame.
   assign accept = in_valid & (frame_start | (state == ST_RUN));
   assign base   = (mode == MODE_CONV2) ? ADDR_WIDTH'(CONV2_BASE)
                                        : ADDR_WIDTH'(CONV1_BASE);

   quant_relu_sat #(
      .BIAS_SHIFT (BIAS_SHIFT)
   ) u_qrs (
      .clk       (clk),
      .srstn     (srstn),
      .flush     (frame_start),
      .in_valid  (accept),
      .data_in   (data_in),
      .bias      (bias),
      .out_shift (shift_q),
      .out_valid (q_valid),
      .act       (q_act)
   );

   // Lane 0 lands in the most significant byte.
   always_comb begin
      lane_sh   = {~lane, 3'b000};
      lane_word = pack_word | ({{(DATA_W-ACT_W){1'b0}}, q_act} << lane_sh);
      pix_last  = (out_cnt + 1'b1) == total_q;
   end

   always_ff @(posedge clk) begin
      if (!srstn) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         sram_wen   <= 1'b0;
         sram_waddr <= '0;
         sram_wdata <= '0;
         total_q    <= '0;
         in_cnt     <= '0;
         out_cnt    <= '0;
         shift_q    <= '0;
         addr       <= '0;
         lane       <= '0;
         pack_word  <= '0;
         last_wr    <= 1'b0;
      end else begin
         sram_wen <= 1'b0;
         done     <= 1'b0;
         if (frame_start) begin
            busy      <= 1'b1;
            total_q   <= pixel_total;
            shift_q   <= out_shift;
            addr      <= base;
            in_cnt    <= in_valid ? CNT_W'(1) : '0;
            out_cnt   <= '0;
            lane      <= '0;
            pack_word <= '0;
            last_wr   <= 1'b0;
            state     <= (in_valid && pixel_total == CNT_W'(1)) ? ST_FLUSH : ST_RUN;
         end else begin
            case (state)
               ST_RUN: begin
                  if (accept) begin
                     in_cnt <= in_cnt + 1'b1;
                     if ((in_cnt + 1'b1) == total_q) state <= ST_FLUSH;
                  end
               end
               ST_FLUSH: begin
                  if (last_wr) begin
                     state   <= ST_DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     last_wr <= 1'b0;
                  end
               end
               ST_DONE:  state <= ST_IDLE;
               default:  state <= ST_IDLE;
            endcase

            // Packer: full word on lane 3, zero-padded word on the frame's last pixel
            if (q_valid) begin
               out_cnt <= out_cnt + 1'b1;
               if (lane == LANE_W'(PACK-1) || pix_last) begin
                  sram_wen   <= 1'b1;
                  sram_waddr <= addr;
                  sram_wdata <= lane_word;
                  addr       <= addr + 1'b1;
                  pack_word  <= '0;
                  lane       <= '0;
                  if (pix_last) last_wr <= 1'b1;
               end else begin
                  pack_word <= lane_word;
                  lane      <= lane + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_quant_pack.sv
// Scoreboard bench for conv_quant_pack: a reference model queues expected
// SRAM writes as pixels are driven; a monitor pops them as the DUT writes.
module tb_conv_quant_pack;

   logic        clk = 1'b0;
   logic        srstn;
   logic [1:0]  mode;
   logic        frame_start;
   logic [11:0] pixel_total;
   logic [4:0]  out_shift;
   logic        in_valid;
   logic [31:0] data_in;
   logic [7:0]  bias;
   logic        sram_wen;
   logic [9:0]  sram_waddr;
   logic [31:0] sram_wdata;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   conv_quant_pack #(
      .BIAS_SHIFT (4),
      .ADDR_WIDTH (10),
      .CONV1_BASE (0),
      .CONV2_BASE (256)
   ) dut (
      .clk         (clk),
      .srstn       (srstn),
      .mode        (mode),
      .frame_start (frame_start),
      .pixel_total (pixel_total),
      .out_shift   (out_shift),
      .in_valid    (in_valid),
      .data_in     (data_in),
      .bias        (bias),
      .sram_wen    (sram_wen),
      .sram_waddr  (sram_waddr),
      .sram_wdata  (sram_wdata),
      .busy        (busy),
      .done        (done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
      bit          last;
   } wr_t;

   wr_t exp_q[$];

   // Reference model state
   bit          m_active;
   int          m_total, m_cnt, m_lane, m_shift;
   logic [31:0] m_word;
   logic [9:0]  m_addr;

   function automatic logic [7:0] model_act(input int d, input int b, input int sh);
      longint s;
      s = longint'(d) + longint'(b) * 16;
      if (s < 0) s = 0;
      if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >> sh;
      if (s > 127) s = 127;
      return s[7:0];
   endfunction

   task automatic model_start(input int md, input int tot, input int sh);
      m_active = 1'b1;
      m_total  = tot;
      m_cnt    = 0;
      m_lane   = 0;
      m_word   = '0;
      m_shift  = sh;
      m_addr   = (md == 2) ? 10'd256 : 10'd0;
   endtask

   task automatic model_pix(input int d, input int b);
      wr_t w;
      if (!m_active || m_cnt >= m_total) return;
      m_word[31 - 8*m_lane -: 8] = model_act(d, b, m_shift);
      m_cnt++;
      m_lane++;
      if (m_lane == 4 || m_cnt == m_total) begin
         w.addr = m_addr;
         w.data = m_word;
         w.last = (m_cnt == m_total);
         exp_q.push_back(w);
         m_addr = m_addr + 10'd1;
         m_word = '0;
         m_lane = 0;
         if (w.last) m_active = 1'b0;
      end
   endtask

   // Monitor: compare every write and the done pulse that must follow the last word
   bit done_due = 1'b0;
   always @(negedge clk) begin
      wr_t e;
      bit  nxt_due;
      nxt_due = 1'b0;
      if (done || done_due) begin
         check("done", done, done_due);
         if (done) check("busy_at_done", busy, 1'b0);
      end
      if (sram_wen) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 1'b1, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("waddr", sram_waddr, e.addr);
            check("wdata", sram_wdata, e.data);
            nxt_due = e.last;
         end
      end
      done_due = nxt_due;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input int md, input int tot, input int sh,
                              input bit with_pix, input int d, input int b);
      mode        = 2'(md);
      pixel_total = 12'(tot);
      out_shift   = 5'(sh);
      frame_start = 1'b1;
      in_valid    = with_pix;
      data_in     = 32'(d);
      bias        = 8'(b);
      model_start(md, tot, sh);
      if (with_pix) model_pix(d, b);
      tick();
      frame_start = 1'b0;
      in_valid    = 1'b0;
   endtask

   task automatic send_pix(input int d, input int b);
      in_valid = 1'b1;
      data_in  = 32'(d);
      bias     = 8'(b);
      model_pix(d, b);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || done_due || busy) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check("timeout", 1'b0, 1'b1);
      repeat (2) tick();
   endtask

   int gd[10];
   int gb[10];

   initial begin
      srstn       = 1'b0;
      mode        = 2'd0;
      frame_start = 1'b0;
      pixel_total = 12'd0;
      out_shift   = 5'd0;
      in_valid    = 1'b0;
      data_in     = 32'd0;
      bias        = 8'd0;
      m_active    = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_wen",   sram_wen,   1'b0);
      check("rst_waddr", sram_waddr, 10'd0);
      check("rst_wdata", sram_wdata, 32'd0);
      check("rst_busy",  busy,       1'b0);
      check("rst_done",  done,       1'b0);
      srstn = 1'b1;
      tick();

      // Basic CONV1 frame: ReLU clamp and saturation
      start_frame(1, 4, 0, 1'b0, 0, 0);
      @(negedge clk);
      check("busy_run", busy, 1'b1);
      tick();
      send_pix(5, 0);
      send_pix(-3, 0);
      send_pix(200, 0);
      send_pix(127, 0);
      wait_idle(40);

      // Rounding with scaled bias
      start_frame(1, 4, 2, 1'b0, 0, 0);
      send_pix(6, 1);
      send_pix(-40, 1);
      send_pix(32'h7fffffff, 1);
      send_pix(2040, -128);
      wait_idle(40);

      // CONV2 partial final word
      start_frame(2, 6, 0, 1'b0, 0, 0);
      for (int i = 1; i <= 6; i++) send_pix(i, 0);
      wait_idle(40);

      // Restart after two pixels; new frame starts with a pixel on frame_start
      start_frame(1, 4, 0, 1'b0, 0, 0);
      send_pix(11, 0);
      send_pix(12, 0);
      start_frame(1, 4, 0, 1'b1, 9, 0);
      send_pix(8, 0);
      send_pix(7, 0);
      send_pix(6, 0);
      wait_idle(40);

      // Single-pixel frame launched together with its pixel
      start_frame(2, 1, 1, 1'b1, 33, 0);
      wait_idle(40);

      // Reset in the middle of a frame
      start_frame(2, 8, 0, 1'b0, 0, 0);
      send_pix(1, 0);
      send_pix(2, 0);
      send_pix(3, 0);
      srstn = 1'b0;
      m_active = 1'b0;
      exp_q.delete();
      tick();
      @(negedge clk);
      check("mid_rst_wen",   sram_wen,   1'b0);
      check("mid_rst_waddr", sram_waddr, 10'd0);
      check("mid_rst_wdata", sram_wdata, 32'd0);
      check("mid_rst_busy",  busy,       1'b0);
      check("mid_rst_done",  done,       1'b0);
      srstn = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) send_pix(50 + i, 0);
      repeat (8) tick();
      @(negedge clk);
      check("idle_after_rst_busy", busy, 1'b0);
      tick();

      // Gapped stream with extras, then the same data gap-free
      for (int i = 0; i < 10; i++) begin
         gd[i] = int'($urandom_range(0, 6000)) - 2000;
         gb[i] = int'($urandom_range(0, 255)) - 128;
      end
      start_frame(2, 10, 3, 1'b0, 0, 0);
      for (int i = 0; i < 13; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         send_pix(gd[i % 10], gb[i % 10]);
      end
      wait_idle(60);
      start_frame(1, 10, 3, 1'b0, 0, 0);
      for (int i = 0; i < 13; i++) send_pix(gd[i % 10], gb[i % 10]);
      wait_idle(60);

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
